pcie_ctrl_adapter: RTL

PCIE_CTRL_ADAPTER -- requirements
Module: pcie_ctrl_adapter

---
 rtl/hififo_pkg.sv | 23 ++
 rtl/hififo_rr_arb.sv | 36 +++
 rtl/pcie_ctrl_adapter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hififo_pkg.sv
// Shared types and helpers for the PCIe control adapter.
// Holds the interrupt FSM state encoding and the width helpers used by the
// top level and the round-robin arbiter.
package hififo_pkg;

  // Interrupt request FSM: wait for work, present the MSI, then hold off.
  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_HOLD = 2'd2
  } irq_state_t;

  // Width of the outstanding-read counter, sized so MAX_OUTSTANDING itself fits.
  function automatic int ocw_calc(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  // Width of a channel index; at least one bit so single-channel builds stay legal.
  function automatic int idx_width(input int nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

endpackage

// File: rtl/hififo_rr_arb.sv
// Round-robin channel selector for the MSI path.
// Purely combinational: given the request bits and the last-served channel,
// returns the first requesting channel after it as a one-hot grant and index.
module hififo_rr_arb
  import hififo_pkg::*;
#(
  parameter  int NCHAN = 4,
  localparam int IW    = idx_width(NCHAN)
) (
  input  logic [NCHAN-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [NCHAN-1:0] grant,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] pos;

  // Scan from the farthest candidate to the nearest so the nearest one after
  // the last-served channel overwrites any earlier hit and wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a value unassigned and infer a latch.
    grant = '0;
    idx   = '0;
    pos   = '0;
    for (int k = NCHAN; k >= 1; k--) begin
      pos = IW'((int'(last) + k) % NCHAN);
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/pcie_ctrl_adapter.sv
// PCIe core control adapter: fabric reset, MSI request sequencing,
// outstanding non-posted read tracking and turn-off acknowledge.
// Optional feature: define HIFIFO_MSI_MULTI_EN for multi-vector MSI, where
// each channel gets its own vector (clamped to the host grant) and only the
// served channel's pending bit clears. Without it a single vector 0 is used
// and one accepted MSI clears every bit that was pending when it was issued.
module pcie_ctrl_adapter
  import hififo_pkg::*;
#(
  parameter  int NCHAN           = 4,
  parameter  int MAX_OUTSTANDING = 32,
  parameter  int HOLDOFF         = 16,
  localparam int OCW             = ocw_calc(MAX_OUTSTANDING),
  localparam int IW              = idx_width(NCHAN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             user_reset,
  input  logic             user_lnk_up,
  output logic             pci_reset,
  input  logic [NCHAN-1:0] int_req,
  output logic             cfg_interrupt,
  input  logic             cfg_interrupt_rdy,
  output logic [7:0]       cfg_interrupt_di,
  input  logic [2:0]       cfg_interrupt_mmenable,
  input  logic             cfg_interrupt_msienable,
  input  logic             rd_issue,
  input  logic             cpl_done,
  output logic [OCW-1:0]   outstanding,
  output logic             rd_allow,
  input  logic             cfg_to_turnoff,
  input  logic             tx_busy,
  output logic             cfg_turnoff_ok
);

  localparam logic [OCW-1:0] MAX_OCW   = OCW'(MAX_OUTSTANDING);
  localparam logic [7:0]     HOLD_LOAD = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

  irq_state_t       state;
  logic [NCHAN-1:0] pending;
  logic [NCHAN-1:0] clr_mask;
  logic [IW-1:0]    last_served;
  logic [IW-1:0]    sel_idx;
  logic [7:0]       hold_cnt;
  logic [NCHAN-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic [7:0]       di_next;
  logic             link_rst;
  logic             rst_next;
  logic             accept;
  logic             irq_start;

  // Fabric-side reset causes; rst_next is the value pci_reset takes next edge,
  // letting dependent state clear in the same cycle pci_reset rises.
  assign link_rst  = user_reset | ~user_lnk_up;
  assign rst_next  = reset | link_rst;
  assign accept    = (state == IRQ_REQ) & cfg_interrupt & cfg_interrupt_rdy;
  assign irq_start = (state == IRQ_IDLE) & (|pending) & cfg_interrupt_msienable
                   & ~pci_reset & ~rst_next;

  hififo_rr_arb #(.NCHAN(NCHAN)) u_rr_arb (
    .req   (pending),
    .last  (last_served),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

`ifdef HIFIFO_MSI_MULTI_EN
  logic [7:0] max_vec;
  logic [7:0] chan_vec;
  logic       unused_state;

  // Highest vector the host granted is 2^mmenable - 1; higher channels share it.
  assign max_vec  = 8'((9'd1 << cfg_interrupt_mmenable) - 9'd1);
  assign chan_vec = 8'(arb_idx);
  assign di_next  = (chan_vec > max_vec) ? max_vec : chan_vec;
  assign unused_state = 1'b0;
`else
  logic unused_state;

  // Single-vector build: the vector number and per-channel grant are not needed.
  assign di_next      = 8'd0;
  assign unused_state = ^{cfg_interrupt_mmenable, arb_grant};
`endif

  // Registered fabric reset, forced high while the block itself is in reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flip-flops.
    if (reset) pci_reset <= 1'b1;
    else       pci_reset <= link_rst;
  end

  // Pending interrupt bits: a new request wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous and sampled only on the clock edge, so it is
    // the first branch of the clocked block rather than in the sensitivity list.
    if (reset) pending <= '0;
    else       pending <= (accept ? (pending & ~clr_mask) : pending) | int_req;
  end

  // Interrupt FSM with registered cfg_interrupt / vector outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IRQ_IDLE;
      cfg_interrupt    <= 1'b0;
      cfg_interrupt_di <= 8'd0;
      last_served      <= IW'(NCHAN - 1);
      sel_idx          <= '0;
      clr_mask         <= '0;
      hold_cnt         <= 8'd0;
    end else begin
      unique case (state)
        IRQ_IDLE: begin
          if (irq_start) begin
            state            <= IRQ_REQ;
            cfg_interrupt    <= 1'b1;
            cfg_interrupt_di <= di_next;
            sel_idx          <= arb_idx;
`ifdef HIFIFO_MSI_MULTI_EN
            clr_mask         <= arb_grant;
`else
            clr_mask         <= pending;
`endif
          end
        end
        IRQ_REQ: begin
          // An accepted MSI completes even if the link drops in the same cycle.
          if (accept) begin
            cfg_interrupt <= 1'b0;
            last_served   <= sel_idx;
            if (HOLDOFF == 0) begin
              state <= IRQ_IDLE;
            end else begin
              state    <= IRQ_HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end else if (rst_next || pci_reset) begin
            // Abandon the request; pending bits stay so it is reissued later.
            state         <= IRQ_IDLE;
            cfg_interrupt <= 1'b0;
          end
        end
        IRQ_HOLD: begin
          if (hold_cnt == 8'd0) state    <= IRQ_IDLE;
          else                  hold_cnt <= hold_cnt - 8'd1;
        end
        default: begin
          state         <= IRQ_IDLE;
          cfg_interrupt <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding non-posted reads, saturating at both ends.
  always_ff @(posedge clock) begin
    if (reset || link_rst || pci_reset) begin
      outstanding <= '0;
    end else if (rd_issue && !cpl_done && (outstanding != MAX_OCW)) begin
      outstanding <= outstanding + OCW'(1);
    end else if (cpl_done && !rd_issue && (outstanding != '0)) begin
      outstanding <= outstanding - OCW'(1);
    end
  end

  assign rd_allow = (outstanding < MAX_OCW) & ~cfg_to_turnoff & ~pci_reset;

  // Turn-off acknowledge: set once the link is quiet, held until the request drops.
  always_ff @(posedge clock) begin
    if (reset)                                   cfg_turnoff_ok <= 1'b0;
    else if (!cfg_to_turnoff)                    cfg_turnoff_ok <= 1'b0;
    else if ((outstanding == '0) && !tx_busy)    cfg_turnoff_ok <= 1'b1;
  end

endmodule
